// File: rtl/yaw_integrator.sv
// Yaw integrator: calibrates out the gyro offset, then integrates corrected yaw rate
// (plus optional IR fusion term) into a 12-bit modular heading. Optional macro: DEADBAND_EN.
module yaw_integrator #(
    parameter int FAST_SIM     = 1,
    parameter int FUSION_SHIFT = 6,
    parameter int DEADBAND     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cal,
    input  logic        vld,
    input  logic [15:0] yaw_rt,
    input  logic        moving,
    input  logic        en_fusion,
    input  logic [8:0]  IR_Dtrm,
    output logic        cal_done,
    output logic        rdy,
    output logic [11:0] heading
);

    localparam int          CAL_LOG2 = (FAST_SIM != 0) ? 8 : 11;
    localparam logic [10:0] CAL_LAST = 11'((1 << CAL_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

    state_t      state_q, state_d;
    logic [26:0] cal_sum_q, cal_sum_d;
    logic [10:0] cal_cnt_q, cal_cnt_d;
    logic [15:0] offset_q, offset_d;
    logic [26:0] acc_q, acc_d;
    logic        s1_vld_q, s1_vld_d;
    logic [15:0] yc_q, yc_d;
    logic        mov_q, mov_d;
    logic        fus_q, fus_d;
    logic [8:0]  ir_q, ir_d;
    logic        cal_done_q, cal_done_d;
    logic        rdy_q, rdy_d;

    logic signed [16:0] diff;
    logic        [15:0] yc_sat;
    logic        [26:0] yc_ext;
    logic        [26:0] fus_term;

    // Offset-corrected rate, saturated to 16 bits when the 17-bit difference overflows.
    always_comb begin
        diff   = $signed({yaw_rt[15], yaw_rt}) - $signed({offset_q[15], offset_q});
        yc_sat = diff[15:0];
        if (diff[16] != diff[15]) begin
            yc_sat = diff[16] ? 16'h8000 : 16'h7FFF;
        end
`ifdef DEADBAND_EN
        if (($signed(yc_sat) > -$signed(16'(DEADBAND))) && ($signed(yc_sat) < $signed(16'(DEADBAND)))) begin
            yc_sat = 16'h0000;
        end
`endif
    end

    always_comb begin
        yc_ext   = {{11{yc_q[15]}}, yc_q};
        fus_term = fus_q ? ({{18{ir_q[8]}}, ir_q} << FUSION_SHIFT) : 27'd0;
    end

    always_comb begin
        state_d    = state_q;
        cal_sum_d  = cal_sum_q;
        cal_cnt_d  = cal_cnt_q;
        offset_d   = offset_q;
        acc_d      = acc_q;
        s1_vld_d   = 1'b0;
        yc_d       = yc_q;
        mov_d      = mov_q;
        fus_d      = fus_q;
        ir_d       = ir_q;
        cal_done_d = 1'b0;
        rdy_d      = 1'b0;

        // A calibration request wins over everything, including samples still in the pipe.
        if (strt_cal) begin
            state_d   = CAL;
            cal_sum_d = 27'd0;
            cal_cnt_d = 11'd0;
            acc_d     = 27'd0;
        end else begin
            if (s1_vld_q) begin
                rdy_d = 1'b1;
                if (mov_q) begin
                    acc_d = acc_q + yc_ext + fus_term;
                end
            end
            case (state_q)
                CAL: begin
                    if (vld) begin
                        cal_sum_d = cal_sum_q + {{11{yaw_rt[15]}}, yaw_rt};
                        cal_cnt_d = cal_cnt_q + 11'd1;
                        if (cal_cnt_q == CAL_LAST) begin
                            offset_d   = 16'($signed(cal_sum_d) >>> CAL_LOG2);
                            cal_cnt_d  = 11'd0;
                            state_d    = RUN;
                            cal_done_d = 1'b1;
                            acc_d      = 27'd0;
                        end
                    end
                end
                RUN: begin
                    if (vld) begin
                        s1_vld_d = 1'b1;
                        yc_d     = yc_sat;
                        mov_d    = moving;
                        fus_d    = en_fusion;
                        ir_d     = IR_Dtrm;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cal_sum_q  <= 27'd0;
            cal_cnt_q  <= 11'd0;
            offset_q   <= 16'd0;
            acc_q      <= 27'd0;
            s1_vld_q   <= 1'b0;
            yc_q       <= 16'd0;
            mov_q      <= 1'b0;
            fus_q      <= 1'b0;
            ir_q       <= 9'd0;
            cal_done_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cal_sum_q  <= cal_sum_d;
            cal_cnt_q  <= cal_cnt_d;
            offset_q   <= offset_d;
            acc_q      <= acc_d;
            s1_vld_q   <= s1_vld_d;
            yc_q       <= yc_d;
            mov_q      <= mov_d;
            fus_q      <= fus_d;
            ir_q       <= ir_d;
            cal_done_q <= cal_done_d;
            rdy_q      <= rdy_d;
        end
    end

    assign heading  = acc_q[26:15];
    assign cal_done = cal_done_q;
    assign rdy      = rdy_q;

endmodule

// File: tb/tb_yaw_integrator.sv
// Scoreboard bench for yaw_integrator: the driver predicts each rdy/cal_done event
// from a behavioural model, and a monitor pops and compares whenever the DUT reports one.
module tb_yaw_integrator;

    logic        clk = 1'b0;
    logic        rst, strt_cal, vld, moving, en_fusion;
    logic [15:0] yaw_rt;
    logic [8:0]  IR_Dtrm;
    logic        cal_done, rdy;
    logic [11:0] heading;

    yaw_integrator dut (
        .clk(clk), .rst(rst), .strt_cal(strt_cal), .vld(vld), .yaw_rt(yaw_rt),
        .moving(moving), .en_fusion(en_fusion), .IR_Dtrm(IR_Dtrm),
        .cal_done(cal_done), .rdy(rdy), .heading(heading)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_cal;
        int          cyc;
        logic [11:0] hd;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    localparam longint MOD   = 64'd1 << 27;
    localparam int     NCAL  = 256;

    // Reference model state: 0 idle, 1 calibrating, 2 running.
    int     m_mode = 0;
    longint m_sum  = 0;
    int     m_cnt  = 0;
    longint m_off  = 0;
    longint m_acc  = 0;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [11:0] hd_of(input longint a);
        logic [63:0] v;
        v = a;
        return v[26:15];
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit v, input logic [15:0] y,
                                 input bit mv, input bit ef, input logic [8:0] ir);
        longint ys, irs, ycv, delta;
        exp_t   e;
        @(posedge clk);
        #1;
        rst = r; strt_cal = s; vld = v; yaw_rt = y; moving = mv; en_fusion = ef; IR_Dtrm = ir;
        ys  = $signed(y);
        irs = $signed(ir);
        if (r || s) begin
            while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
            m_acc = 0; m_sum = 0; m_cnt = 0;
            if (r) begin
                m_mode = 0;
                m_off  = 0;
            end else begin
                m_mode = 1;
            end
        end else if (v) begin
            if (m_mode == 1) begin
                m_sum = m_sum + ys;
                m_cnt++;
                if (m_cnt == NCAL) begin
                    m_off  = floor_div(m_sum, NCAL);
                    m_mode = 2;
                    m_acc  = 0; m_sum = 0; m_cnt = 0;
                    e.is_cal = 1'b1; e.cyc = cyc + 1; e.hd = 12'h000;
                    exp_q.push_back(e);
                end
            end else if (m_mode == 2) begin
                ycv = ys - m_off;
                if (ycv > 32767)  ycv = 32767;
                if (ycv < -32768) ycv = -32768;
`ifdef DEADBAND_EN
                if (ycv > -4 && ycv < 4) ycv = 0;
`endif
                delta = mv ? (ycv + (ef ? irs * 64 : 0)) : 0;
                m_acc = (m_acc + delta) % MOD;
                if (m_acc < 0) m_acc = m_acc + MOD;
                e.is_cal = 1'b0; e.cyc = cyc + 2; e.hd = hd_of(m_acc);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 16'h0, 0, 0, 9'h0);
    endtask

    task automatic vldn(input int n, input logic [15:0] y, input bit mv, input bit ef, input logic [8:0] ir);
        repeat (n) applyStimulus(0, 0, 1, y, mv, ef, ir);
    endtask

    task automatic calib(input logic [15:0] y);
        applyStimulus(0, 1, 0, 16'h0, 0, 0, 9'h0);
        vldn(NCAL, y, 0, 0, 9'h0);
        idle(2);
    endtask

    // Monitor: every rdy/cal_done must match the oldest prediction, in cycle, kind and heading.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing_event: got none expected %s at cycle %0d",
                         e.is_cal ? "cal_done" : "rdy", e.cyc);
            end
            if (rdy || cal_done) begin
                checkOutput("rdy_cal_overlap", rdy & cal_done, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event: got rdy=%0b cal_done=%0b expected none at cycle %0d",
                             rdy, cal_done, cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_cycle", cyc, e.cyc);
                    checkOutput("event_kind", cal_done, e.is_cal);
                    checkOutput("heading", heading, e.hd);
                end
            end
        end
    end

    initial begin
        bit          r, s, v;
        logic [15:0] y;
        rst = 1'b1; strt_cal = 0; vld = 0; yaw_rt = 0; moving = 0; en_fusion = 0; IR_Dtrm = 0;

        repeat (3) applyStimulus(1, 0, 0, 16'h0, 0, 0, 9'h0);
        idle(1);
        checkOutput("reset_heading", heading, 0);
        checkOutput("reset_rdy", rdy, 0);
        checkOutput("reset_cal_done", cal_done, 0);

        $display("[TB] idle samples are ignored");
        vldn(5, 16'h1234, 1, 0, 9'h0);
        idle(3);

        $display("[TB] calibration and integration");
        calib(16'h0010);
        vldn(1, 16'h0010, 1, 0, 9'h0);
        idle(3);
        checkOutput("cal_zero_heading", heading, 12'h000);
        vldn(2048, 16'h4010, 1, 0, 9'h0);
        idle(3);
        checkOutput("integ_90", heading, 12'h400);
        vldn(4096, 16'h4010, 1, 0, 9'h0);
        idle(3);
        checkOutput("integ_270", heading, 12'hC00);
        vldn(4096, 16'h4010, 1, 0, 9'h0);
        idle(3);
        checkOutput("integ_wrap", heading, 12'h400);

        $display("[TB] fusion");
        calib(16'h0000);
        vldn(2, 16'h0000, 1, 1, 9'h100);
        idle(3);
        checkOutput("fusion_moving", heading, 12'hFFF);
        calib(16'h0000);
        vldn(2, 16'h0000, 0, 1, 9'h100);
        idle(3);
        checkOutput("fusion_still", heading, 12'h000);

        $display("[TB] saturation");
        calib(16'h8300);
        vldn(1, 16'h7D00, 1, 0, 9'h0);
        idle(3);
        checkOutput("sat_one", heading, 12'h000);
        vldn(1, 16'h7D00, 1, 0, 9'h0);
        idle(3);
        checkOutput("sat_two", heading, 12'h001);
        vldn(3, 16'h8000, 1, 0, 9'h0);
        idle(3);

        $display("[TB] strt_cal priority and flush");
        calib(16'h0000);
        vldn(4, 16'h7000, 1, 0, 9'h0);
        applyStimulus(0, 1, 1, 16'h7000, 1, 0, 9'h0);
        idle(3);
        checkOutput("strt_clears_acc", heading, 12'h000);
        vldn(4, 16'h1000, 1, 0, 9'h0);
        idle(3);

        $display("[TB] reset mid-calibration");
        applyStimulus(0, 1, 0, 16'h0, 0, 0, 9'h0);
        vldn(100, 16'h0020, 0, 0, 9'h0);
        applyStimulus(1, 0, 0, 16'h0, 0, 0, 9'h0);
        vldn(5, 16'h0020, 1, 0, 9'h0);
        applyStimulus(0, 1, 0, 16'h0, 0, 0, 9'h0);
        vldn(NCAL - 1, 16'hFFF1, 0, 0, 9'h0);
        idle(3);
        checkOutput("no_early_cal_done", cal_done, 0);
        vldn(1, 16'hFFF1, 0, 0, 9'h0);
        idle(2);
        vldn(3, 16'h0100, 1, 1, 9'h0FF);
        idle(3);

        $display("[TB] small rate drift");
        calib(16'h0000);
        vldn(4096, 16'h0003, 1, 0, 9'h0);
        idle(3);
        checkOutput("drift_heading", heading, 12'h000);

        $display("[TB] randomized traffic");
        applyStimulus(0, 1, 0, 16'h0, 0, 0, 9'h0);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 1499) == 0);
            s = ($urandom_range(0, 399) == 0) || (m_mode == 0 && $urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 3) != 0);
            y = (m_mode == 1) ? 16'($urandom_range(0, 4095) - 2048) : 16'($urandom);
            applyStimulus(r, s, v, y, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          9'($urandom));
        end
        idle(5);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
